// File: rtl/gpr_debug_access.sv
// Debug-side GPR access controller: halts the core, performs one JTAG read or
// write on the register file, and returns rdata/error over a valid/ready channel.
module gpr_debug_access #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              halt_req_o,
    input  logic              halted_i,
    output logic              jtag_en_o,
    output logic [ADDR_W-1:0] jtag_addr_o,
    output logic [DATA_W-1:0] jtag_wdata_o,
    input  logic [DATA_W-1:0] jtag_rdata_i
);

    localparam int unsigned CNT_W = $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            state, state_n;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  halt_cnt;
    logic              accept;
    logic              addr_zero;

    assign cmd_ready_o = rst_n_i & (state == S_IDLE);
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign addr_zero   = (lat_addr == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        rsp_valid_o  = 1'b0;
        jtag_en_o    = 1'b0;
        jtag_addr_o  = '0;
        jtag_wdata_o = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = halted_i ? S_ACCESS : S_HALT_WAIT;
                end
            end
            S_HALT_WAIT: begin
                if (halted_i) begin
                    state_n = S_ACCESS;
                end else if (halt_cnt == CNT_LAST) begin
                    state_n = S_RESP;
                end
            end
            S_ACCESS: begin
                // Writeback has priority at the register file, so only write while halted.
                jtag_en_o    = lat_write & ~addr_zero & halted_i;
                jtag_addr_o  = lat_addr;
                jtag_wdata_o = lat_write ? lat_wdata : '0;
                state_n      = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            halt_cnt    <= '0;
            halt_req_o  <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_write  <= cmd_write_i;
                        lat_addr   <= cmd_addr_i;
                        lat_wdata  <= cmd_wdata_i;
                        halt_cnt   <= '0;
                        halt_req_o <= 1'b1;
                    end
                end
                S_HALT_WAIT: begin
                    if (halt_cnt != '1) begin
                        halt_cnt <= halt_cnt + CNT_W'(1);
                    end
                    if (!halted_i && halt_cnt == CNT_LAST) begin
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end
                end
                S_ACCESS: begin
                    rsp_err_o   <= ~halted_i | (lat_write & addr_zero);
                    rsp_rdata_o <= (!lat_write && halted_i && !addr_zero) ? jtag_rdata_i : '0;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        halt_req_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
